alu_arbiter: RTL and testbench

- Shares one 16-bit ALU datapath between two requesters (e.g. execute stage and address/branch unit).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Grants by round-robin, drives the ALU operand/op bus for one cycle, and registers r/zero/ovfl.
- Holds the result until the owning requester accepts it.
- The ALU is instantiated outside and wired to the alu_* ports.

---
 rtl/alu_arbiter_pkg.sv | 29 ++
 rtl/alu_arbiter_rr_arb2.sv | 13 +
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants, legal-op check and FSM encoding for alu_arbiter.
package alu_arbiter_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_LAND = 4'd3;
    localparam logic [3:0] OP_LOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SRA);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone valid requester wins, a tie goes to
// whichever requester did not win last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       gnt,
    output logic       gnt_vld
);

    assign gnt     = (valid == 2'b11) ? ~last_grant : valid[1];
    assign gnt_vld = |valid;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two valid/ready requesters (IDLE/ISSUE/RESP).
// Optional ALU_ARB_OVFL_CNT_EN adds a saturating ovfl_count of overflowing responses.
import alu_arbiter_pkg::*;

module alu_arbiter #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_r,
    output logic              rsp0_zero,
    output logic              rsp0_ovfl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_r,
    output logic              rsp1_zero,
    output logic              rsp1_ovfl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zero,
    input  logic              alu_ovfl
`ifdef ALU_ARB_OVFL_CNT_EN
    ,
    output logic [15:0]       ovfl_count
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic              zero;
        logic              ovfl;
    } rsp_t;

    arb_state_e state, state_d;
    logic       last_grant, owner;
    req_t       lat;
    logic       lat_ill;

    req_t [NUM_REQ-1:0] req_in;
    rsp_t [NUM_REQ-1:0] rsp_q;
    logic [NUM_REQ-1:0] req_valid, req_ready, rsp_ready, rsp_vld_q;

    logic gnt, gnt_vld, accept, gnt_legal, rsp_hs;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req_in[0] = '{a: req0_a, b: req0_b, op: req0_op};
    assign req_in[1] = '{a: req1_a, b: req1_b, op: req1_op};

    rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_vld    (gnt_vld)
    );

    assign gnt_legal = op_legal(4'(req_in[gnt].op));
    assign rsp_hs    = (state == RESP) && rsp_vld_q[owner] && rsp_ready[owner];

    always_comb begin
        state_d   = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    req_ready[gnt] = 1'b1;
                    accept         = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat        <= '0;
            lat_ill    <= 1'b0;
            rsp_q      <= '0;
            rsp_vld_q  <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                owner      <= gnt;
                last_grant <= gnt;
                // Illegal ops are latched as all-zero so the ALU bus stays quiet.
                lat        <= gnt_legal ? req_in[gnt] : '0;
                lat_ill    <= ~gnt_legal;
            end
            if (state == ISSUE) begin
                rsp_q[owner]     <= lat_ill ? '{r: '0, zero: 1'b1, ovfl: 1'b0}
                                            : '{r: alu_r, zero: alu_zero, ovfl: alu_ovfl};
                rsp_vld_q[owner] <= 1'b1;
            end
            if (rsp_hs)
                rsp_vld_q[owner] <= 1'b0;
        end
    end

    assign alu_a  = (state == ISSUE) ? lat.a  : '0;
    assign alu_b  = (state == ISSUE) ? lat.b  : '0;
    assign alu_op = (state == ISSUE) ? lat.op : '0;

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_vld_q[0];
    assign rsp1_valid = rsp_vld_q[1];
    assign rsp0_r     = rsp_q[0].r;
    assign rsp0_zero  = rsp_q[0].zero;
    assign rsp0_ovfl  = rsp_q[0].ovfl;
    assign rsp1_r     = rsp_q[1].r;
    assign rsp1_zero  = rsp_q[1].zero;
    assign rsp1_ovfl  = rsp_q[1].ovfl;

`ifdef ALU_ARB_OVFL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovfl_count <= '0;
        else if (rsp_hs && rsp_q[owner].ovfl && (ovfl_count != 16'hFFFF))
            ovfl_count <= ovfl_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* bus.
`timescale 1ns/1ps
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_ovfl;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_ovfl;
    logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp0_r, rsp1_r;
    logic [3:0]  req0_op, req1_op, alu_op;
    logic [15:0] alu_a, alu_b, alu_r;
    logic        alu_zero, alu_ovfl;
`ifdef ALU_ARB_OVFL_CNT_EN
    logic [15:0] ovfl_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(16), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_r(rsp0_r),
        .rsp0_zero(rsp0_zero), .rsp0_ovfl(rsp0_ovfl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r),
        .rsp1_zero(rsp1_zero), .rsp1_ovfl(rsp1_ovfl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovfl(alu_ovfl)
`ifdef ALU_ARB_OVFL_CNT_EN
        , .ovfl_count(ovfl_count)
`endif
    );

    // Unknown opcodes return junk so a missing illegal-op override shows up.
    always_comb begin
        alu_r    = 16'hDEAD;
        alu_ovfl = 1'b1;
        case (alu_op)
            4'd1: begin
                alu_r    = alu_a + alu_b;
                alu_ovfl = (alu_a[15] == alu_b[15]) && (alu_r[15] != alu_a[15]);
            end
            4'd2: begin
                alu_r    = alu_a - alu_b;
                alu_ovfl = (alu_a[15] != alu_b[15]) && (alu_r[15] != alu_a[15]);
            end
            4'd6: begin alu_r = alu_a & alu_b; alu_ovfl = 1'b0; end
            4'd7: begin alu_r = alu_a | alu_b; alu_ovfl = 1'b0; end
            4'd9: begin alu_r = alu_a ^ alu_b; alu_ovfl = 1'b0; end
            default: ;
        endcase
        alu_zero = (alu_r == 16'h0000);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set_req1(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        set_req0(1'b0, 16'h0, 16'h0, 4'h0);
        set_req1(1'b0, 16'h0, 16'h0, 4'h0);
        repeat (2) tick();
        rst = 1'b0;

        // reset state
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_r", rsp0_r, 0);
        chk("rst_rsp1_flags", {rsp1_zero, rsp1_ovfl, rsp0_zero, rsp0_ovfl}, 0);
        chk("rst_alu_bus", {alu_a, alu_b, 12'h0, alu_op}, 0);
        chk("rst_ready_idle", {req1_ready, req0_ready}, 0);
`ifdef ALU_ARB_OVFL_CNT_EN
        chk("rst_ovfl_count", ovfl_count, 0);
`endif

        // single request: req0 ADD 3+4
        set_req0(1'b1, 16'h0003, 16'h0004, 4'd1);
        #1;
        chk("single_req0_ready", req0_ready, 1);
        chk("single_req1_ready", req1_ready, 0);
        tick();
        set_req0(1'b0, 16'hFFFF, 16'hFFFF, 4'd2);
        chk("single_alu_op", alu_op, 1);
        chk("single_alu_ab", {alu_a, alu_b}, 32'h0003_0004);
        chk("single_ready_issue", req0_ready, 0);
        chk("single_rsp0_early", rsp0_valid, 0);
        tick();
        chk("single_rsp0_valid", rsp0_valid, 1);
        chk("single_rsp0_r", rsp0_r, 16'h0007);
        chk("single_rsp0_flags", {rsp0_zero, rsp0_ovfl}, 0);
        chk("single_rsp1_valid", rsp1_valid, 0);
        chk("single_alu_idle", alu_op, 0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("single_rsp0_clr", rsp0_valid, 0);
        chk("single_rsp0_hold", rsp0_r, 16'h0007);

        // overflow: req1 ADD 7FFF+1
        set_req1(1'b1, 16'h7FFF, 16'h0001, 4'd1);
        #1;
        chk("ovf_req1_ready", req1_ready, 1);
        tick();
        set_req1(1'b0, 16'h0, 16'h0, 4'd0);
        chk("ovf_alu_a", alu_a, 16'h7FFF);
        tick();
        chk("ovf_rsp1_valid", rsp1_valid, 1);
        chk("ovf_rsp1_r", rsp1_r, 16'h8000);
        chk("ovf_rsp1_flags", {rsp1_zero, rsp1_ovfl}, 2'b01);
`ifdef ALU_ARB_OVFL_CNT_EN
        chk("ovf_count_before", ovfl_count, 0);
`endif
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        chk("ovf_rsp1_clr", rsp1_valid, 0);
`ifdef ALU_ARB_OVFL_CNT_EN
        chk("ovf_count_after", ovfl_count, 1);
`endif

        // contention: both SUB, last winner was 1 -> order 0,1,0,1
        set_req0(1'b1, 16'h000A, 16'h0003, 4'd2);
        set_req1(1'b1, 16'h0005, 16'h0005, 4'd2);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont%0d_ready", i), {req1_ready, req0_ready},
                (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk($sformatf("cont%0d_issue_ready", i), {req1_ready, req0_ready}, 0);
            tick();
            if (i % 2 == 0) begin
                chk($sformatf("cont%0d_rsp_valid", i), {rsp1_valid, rsp0_valid}, 2'b01);
                chk($sformatf("cont%0d_rsp0", i), {rsp0_r, 14'h0, rsp0_zero, rsp0_ovfl},
                    {16'h0007, 16'h0000});
            end else begin
                chk($sformatf("cont%0d_rsp_valid", i), {rsp1_valid, rsp0_valid}, 2'b10);
                chk($sformatf("cont%0d_rsp1", i), {rsp1_r, 14'h0, rsp1_zero, rsp1_ovfl},
                    {16'h0000, 16'h0002});
            end
            tick();
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // backpressure: req0 XOR wins (last=1), req1 waits behind it
        set_req0(1'b1, 16'h00FF, 16'h0F0F, 4'd9);
        set_req1(1'b1, 16'hF0F0, 16'h0FF0, 4'd6);
        #1;
        chk("bp_grant", {req1_ready, req0_ready}, 2'b01);
        tick();
        set_req0(1'b0, 16'h0, 16'h0, 4'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_rsp0", i), {rsp0_valid, rsp0_r, rsp0_zero, rsp0_ovfl},
                {1'b1, 16'h0FF0, 2'b00});
            chk($sformatf("bp%0d_ready", i), {req1_ready, req0_ready}, 0);
            tick();
        end
        rsp0_ready = 1'b1;
        #1;
        chk("bp_hs_ready", req1_ready, 0);
        tick();
        rsp0_ready = 1'b0;
        chk("bp_next_grant", {req1_ready, rsp0_valid}, 2'b10);
        tick();
        set_req1(1'b0, 16'h0, 16'h0, 4'd0);
        tick();
        chk("bp_rsp1_r", {rsp1_valid, rsp1_r}, {1'b1, 16'h00F0});
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;

        // illegal opcode
        set_req0(1'b1, 16'h1234, 16'h0001, 4'hF);
        #1;
        chk("ill_ready", req0_ready, 1);
        tick();
        set_req0(1'b0, 16'h0, 16'h0, 4'd0);
        chk("ill_alu_bus", {alu_a, alu_b, 12'h0, alu_op}, 0);
        tick();
        chk("ill_rsp0", {rsp0_valid, rsp0_r, rsp0_zero, rsp0_ovfl}, {1'b1, 16'h0000, 2'b10});
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // reset in RESP abandons the op
        set_req0(1'b1, 16'h0001, 16'h0001, 4'd1);
        tick();
        set_req0(1'b0, 16'h0, 16'h0, 4'd0);
        tick();
        chk("rstmid_rsp0_pre", rsp0_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_rsp0_valid", rsp0_valid, 0);
        chk("rstmid_rsp0_r", rsp0_r, 0);
`ifdef ALU_ARB_OVFL_CNT_EN
        chk("rstmid_ovfl_count", ovfl_count, 0);
`endif
        set_req0(1'b1, 16'h0, 16'h0, 4'd1);
        set_req1(1'b1, 16'h0002, 16'h0002, 4'd1);
        #1;
        chk("rstmid_tie_grant", {req1_ready, req0_ready}, 2'b01);
        set_req0(1'b0, 16'h0, 16'h0, 4'd0);
        #1;
        chk("rstmid_req1_grant", {req1_ready, req0_ready}, 2'b10);
        tick();
        set_req1(1'b0, 16'h0, 16'h0, 4'd0);
        tick();
        chk("rstmid_rsp1", {rsp1_valid, rsp0_valid, rsp1_r}, {2'b10, 16'h0004});
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        chk("rstmid_rsp1_clr", rsp1_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
